// File: rtl/i2cmb_slave_pkg.sv
// Shared types for the multi-bus I2C target array.
// State enum, data width and pointer-width helper.
package i2cmb_slave_pkg;

  localparam int I2C_DATA_WIDTH = 8;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WR,
    WR_ACK,
    RD,
    RD_ACK
`ifdef I2CMB_SLV_STRETCH_EN
    , STRETCH
`endif
  } slv_state_t;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/i2cmb_slave_chan.sv
// One I2C register-file target: sync, START/STOP, FSM, memory.
// Ports: clk, rst (async low), scl_i/sda_i, scl_o/sda_o, busy, wr_stb.
// Optional SCL stretching: I2CMB_SLV_STRETCH_EN.
module i2cmb_slave_chan
  import i2cmb_slave_pkg::*;
#(
  parameter logic [6:0] SLV_ADDR = 7'h22,
  parameter int MEM_DEPTH = 32,
  parameter int SYNC_STAGES = 2,
  parameter int STRETCH_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_o,
  output logic sda_o,
  output logic busy,
  output logic wr_stb
);

  localparam int PW = ptr_w(MEM_DEPTH);
  localparam int DW = I2C_DATA_WIDTH;
  localparam logic [3:0] LAST = 4'(DW - 1);

  logic [SYNC_STAGES-1:0] scl_q;
  logic [SYNC_STAGES-1:0] sda_q;
  logic scl_s, sda_s, scl_p, sda_p;
  logic rise, fall, start, stop;

  slv_state_t state, nxt;
  logic [3:0] cnt;
  logic [DW-2:0] sh;
  logic [DW-1:0] nb;
  logic rw, ack_on, nack;
  logic [PW-1:0] ptr;
  logic [DW-1:0] mem [MEM_DEPTH];

  assign scl_s = scl_q[SYNC_STAGES-1];
  assign sda_s = sda_q[SYNC_STAGES-1];
  assign rise  = scl_s & ~scl_p;
  assign fall  = ~scl_s & scl_p;
  assign start = scl_s & scl_p & sda_p & ~sda_s;
  assign stop  = scl_s & scl_p & ~sda_p & sda_s;
  assign nb    = {sh, sda_s};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_q <= '1;
      sda_q <= '1;
      scl_p <= 1'b1;
      sda_p <= 1'b1;
    end else begin
      scl_q <= {scl_q[SYNC_STAGES-2:0], scl_i};
      sda_q <= {sda_q[SYNC_STAGES-2:0], sda_i};
      scl_p <= scl_s;
      sda_p <= sda_s;
    end
  end

  // Where to go once the 9th (ACK/NACK) bit ends.
  always_comb begin
    nxt = WR;
    if (state == ADDR_ACK)
      nxt = rw ? RD : PTR;
    else if (state == RD_ACK)
      nxt = nack ? IDLE : RD;
  end

`ifdef I2CMB_SLV_STRETCH_EN
  localparam int SCW = $clog2(STRETCH_CYCLES + 1);
  slv_state_t ret;
  logic [SCW-1:0] scnt;
`else
  localparam int unused_stretch = STRETCH_CYCLES;
  assign scl_o = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      sh     <= '0;
      rw     <= 1'b0;
      ack_on <= 1'b0;
      nack   <= 1'b0;
      ptr    <= '0;
      sda_o  <= 1'b1;
      busy   <= 1'b0;
      wr_stb <= 1'b0;
`ifdef I2CMB_SLV_STRETCH_EN
      scl_o  <= 1'b1;
      ret    <= IDLE;
      scnt   <= '0;
`endif
      for (int i = 0; i < MEM_DEPTH; i++)
        mem[i] <= 8'(i);
    end else begin
      wr_stb <= 1'b0;
      if (start) begin
        state  <= ADDR;
        cnt    <= '0;
        ack_on <= 1'b0;
        sda_o  <= 1'b1;
`ifdef I2CMB_SLV_STRETCH_EN
        scl_o  <= 1'b1;
`endif
      end else if (stop) begin
        state <= IDLE;
        sda_o <= 1'b1;
        busy  <= 1'b0;
`ifdef I2CMB_SLV_STRETCH_EN
        scl_o <= 1'b1;
`endif
      end else begin
        unique case (state)
          IDLE: ;
          ADDR: if (rise) begin
            sh  <= nb[DW-2:0];
            cnt <= cnt + 4'd1;
            if (cnt == LAST) begin
              cnt <= '0;
              if (nb[DW-1:1] == SLV_ADDR) begin
                state  <= ADDR_ACK;
                rw     <= nb[0];
                busy   <= 1'b1;
                ack_on <= 1'b0;
              end else begin
                state <= IDLE;
              end
            end
          end
          PTR: if (rise) begin
            sh  <= nb[DW-2:0];
            cnt <= cnt + 4'd1;
            if (cnt == LAST) begin
              cnt    <= '0;
              ptr    <= nb[PW-1:0];
              ack_on <= 1'b0;
              state  <= PTR_ACK;
            end
          end
          WR: if (rise) begin
            sh  <= nb[DW-2:0];
            cnt <= cnt + 4'd1;
            if (cnt == LAST) begin
              cnt      <= '0;
              mem[ptr] <= nb;
              wr_stb   <= 1'b1;
              ptr      <= ptr + PW'(1);
              ack_on   <= 1'b0;
              state    <= WR_ACK;
            end
          end
          RD: begin
            if (rise)
              cnt <= cnt + 4'd1;
            if (fall) begin
              if (cnt == 4'd8) begin
                sda_o <= 1'b1;
                cnt   <= '0;
                state <= RD_ACK;
              end else begin
                sda_o <= sh[DW-2];
                sh    <= {sh[DW-3:0], 1'b0};
              end
            end
          end
          ADDR_ACK, PTR_ACK, WR_ACK, RD_ACK: begin
            if (rise && state == RD_ACK)
              nack <= sda_s;
            // First fall ends bit 8 (drive ACK), second ends bit 9.
            if (fall) begin
              if (state != RD_ACK && !ack_on) begin
                sda_o  <= 1'b0;
                ack_on <= 1'b1;
              end else begin
                ack_on <= 1'b0;
                cnt    <= '0;
                sda_o  <= 1'b1;
                if (nxt == RD) begin
                  sh    <= mem[ptr][DW-2:0];
                  sda_o <= mem[ptr][DW-1];
                  ptr   <= ptr + PW'(1);
                end
`ifdef I2CMB_SLV_STRETCH_EN
                state <= STRETCH;
                ret   <= nxt;
                scl_o <= 1'b0;
                scnt  <= '0;
`else
                state <= nxt;
`endif
              end
            end
          end
`ifdef I2CMB_SLV_STRETCH_EN
          STRETCH: begin
            if (scnt == SCW'(STRETCH_CYCLES - 1)) begin
              scl_o <= 1'b1;
              state <= ret;
            end else begin
              scnt <= scnt + SCW'(1);
            end
          end
`endif
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/i2cmb_slave_array.sv
// Array of independent I2C targets, one per bus, at ADDR_BASE+k.
// Ports: clk, rst (async low), scl_i/sda_i/scl_o/sda_o/busy/wr_stb per bus.
// Optional SCL stretching: I2CMB_SLV_STRETCH_EN.
module i2cmb_slave_array
  import i2cmb_slave_pkg::*;
#(
  parameter int NUM_BUSES = 1,
  parameter logic [6:0] ADDR_BASE = 7'h22,
  parameter int MEM_DEPTH = 32,
  parameter int SYNC_STAGES = 2,
  parameter int STRETCH_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic [NUM_BUSES-1:0] scl_i,
  input  logic [NUM_BUSES-1:0] sda_i,
  output logic [NUM_BUSES-1:0] scl_o,
  output logic [NUM_BUSES-1:0] sda_o,
  output logic [NUM_BUSES-1:0] busy,
  output logic [NUM_BUSES-1:0] wr_stb
);

  for (genvar k = 0; k < NUM_BUSES; k++) begin : g_chan
    i2cmb_slave_chan #(
      .SLV_ADDR(7'(ADDR_BASE + k)),
      .MEM_DEPTH(MEM_DEPTH),
      .SYNC_STAGES(SYNC_STAGES),
      .STRETCH_CYCLES(STRETCH_CYCLES)
    ) u_chan (
      .clk(clk),
      .rst(rst),
      .scl_i(scl_i[k]),
      .sda_i(sda_i[k]),
      .scl_o(scl_o[k]),
      .sda_o(sda_o[k]),
      .busy(busy[k]),
      .wr_stb(wr_stb[k])
    );
  end

endmodule

// File: tb/tb_i2cmb_slave_array.sv
// Bench for i2cmb_slave_array: bit-banged masters per bus,
// reference register-file model, randomized data.
module tb_i2cmb_slave_array;

  localparam int NB = 4;
  localparam int DEPTH = 32;
  localparam logic [6:0] BASE = 7'h22;
  localparam int SC = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  wire [NB-1:0] scl_w, sda_w;
  logic [NB-1:0] scl_o, sda_o, busy, wr_stb;
  logic m_scl [NB] = '{default: 1'b1};
  logic m_sda [NB] = '{default: 1'b1};
  int total = 0;
  int bad = 0;
  int stb [NB] = '{default: 0};
  logic [7:0] mdl [NB][DEPTH];
  int mptr [NB];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NB; g++) begin : g_bus
    assign scl_w[g] = m_scl[g] & scl_o[g];
    assign sda_w[g] = m_sda[g] & sda_o[g];
  end

  i2cmb_slave_array #(
    .NUM_BUSES(NB),
    .ADDR_BASE(BASE),
    .MEM_DEPTH(DEPTH),
    .SYNC_STAGES(2),
    .STRETCH_CYCLES(SC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .scl_i(scl_w),
    .sda_i(sda_w),
    .scl_o(scl_o),
    .sda_o(sda_o),
    .busy(busy),
    .wr_stb(wr_stb)
  );

  always @(posedge clk)
    for (int i = 0; i < NB; i++)
      if (wr_stb[i] === 1'b1) stb[i] <= stb[i] + 1;

`ifdef I2CMB_SLV_STRETCH_EN
  int run = 0;
  int runs = 0;
  int run_bad = 0;
  always @(negedge clk)
    if (scl_o[0] === 1'b0) run <= run + 1;
    else if (run != 0) begin
      runs <= runs + 1;
      if (run != SC) run_bad <= run_bad + 1;
      run <= 0;
    end
`endif

  initial begin
    repeat (95000) @(posedge clk);
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  // ---- reference model ----
  task automatic mdl_reset();
    for (int b = 0; b < NB; b++) begin
      mptr[b] = 0;
      for (int i = 0; i < DEPTH; i++) mdl[b][i] = 8'(i);
    end
  endtask

  task automatic mdl_wr(int b, logic [7:0] p, int n,
                        input logic [7:0] d [8]);
    mptr[b] = int'(p) % DEPTH;
    for (int i = 0; i < n; i++) begin
      mdl[b][mptr[b]] = d[i];
      mptr[b] = (mptr[b] + 1) % DEPTH;
    end
  endtask

  task automatic mdl_rd(int b, int n, output logic [7:0] q [8]);
    q = '{default: 8'h00};
    for (int i = 0; i < n; i++) begin
      q[i] = mdl[b][mptr[b]];
      mptr[b] = (mptr[b] + 1) % DEPTH;
    end
  endtask

  // ---- bit-level master ----
  task automatic wclk(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic whigh(int b);
    int k = 0;
    while (scl_w[b] !== 1'b1 && k < 400) begin
      @(negedge clk);
      k++;
    end
    if (k >= 400) begin
      bad++;
      $display("FAIL scl_high bus=%0d got=low want=high", b);
    end
  endtask

  task automatic bitx(int b, logic v, output logic r);
    wclk(4);
    m_sda[b] = v;
    wclk(4);
    m_scl[b] = 1'b1;
    whigh(b);
    wclk(4);
    r = sda_w[b];
    wclk(4);
    m_scl[b] = 1'b0;
  endtask

  task automatic i2c_start(int b);
    m_sda[b] = 1'b1;
    wclk(4);
    m_scl[b] = 1'b1;
    whigh(b);
    wclk(6);
    m_sda[b] = 1'b0;
    wclk(6);
    m_scl[b] = 1'b0;
  endtask

  task automatic i2c_stop(int b);
    wclk(4);
    m_sda[b] = 1'b0;
    wclk(4);
    m_scl[b] = 1'b1;
    whigh(b);
    wclk(6);
    m_sda[b] = 1'b1;
    wclk(6);
  endtask

  task automatic wr_byte(int b, logic [7:0] d, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bitx(b, d[i], r);
    bitx(b, 1'b1, r);
    ack = (r === 1'b0);
  endtask

  task automatic rd_byte(int b, logic last, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bitx(b, 1'b1, r);
      d[i] = r;
    end
    bitx(b, last, r);
  endtask

  function automatic logic [6:0] adr(int b);
    return 7'(int'(BASE) + b);
  endfunction

  task automatic wr_txn(int b, logic [7:0] p, int n,
                        input logic [7:0] d [8], output int nak);
    logic a;
    nak = 0;
    i2c_start(b);
    wr_byte(b, {adr(b), 1'b0}, a);
    if (!a) nak++;
    wr_byte(b, p, a);
    if (!a) nak++;
    for (int i = 0; i < n; i++) begin
      wr_byte(b, d[i], a);
      if (!a) nak++;
    end
    i2c_stop(b);
  endtask

  task automatic rd_txn(int b, logic setp, logic [7:0] p, int n,
                        output logic [7:0] q [8], output int nak);
    logic a;
    logic [7:0] z [8];
    z = '{default: 8'h00};
    q = '{default: 8'h00};
    nak = 0;
    if (setp) wr_txn(b, p, 0, z, nak);
    i2c_start(b);
    wr_byte(b, {adr(b), 1'b1}, a);
    if (!a) nak++;
    for (int i = 0; i < n; i++) rd_byte(b, (i == n - 1), q[i]);
    i2c_stop(b);
  endtask

  // ---- scenarios ----
  task automatic test_reset();
    logic [7:0] q [8], e [8];
    int nak;
    rst = 1'b0;
    wclk(3);
    total++;
    if (scl_o !== '1) begin
      bad++; $display("FAIL rst_scl got=%b want=1111", scl_o);
    end
    total++;
    if (sda_o !== '1) begin
      bad++; $display("FAIL rst_sda got=%b want=1111", sda_o);
    end
    total++;
    if (busy !== '0 || wr_stb !== '0) begin
      bad++; $display("FAIL rst_busy got=%b/%b want=0", busy, wr_stb);
    end
    rst = 1'b1;
    mdl_reset();
    wclk(5);
    rd_txn(2, 1'b0, 8'h00, 2, q, nak);
    mdl_rd(2, 2, e);
    total++;
    if (nak != 0) begin
      bad++; $display("FAIL rst_rd_ack got=%0d want=0", nak);
    end
    for (int i = 0; i < 2; i++) begin
      total++;
      if (q[i] !== e[i]) begin
        bad++; $display("FAIL rst_rd%0d got=%h want=%h", i, q[i], e[i]);
      end
    end
  endtask

  task automatic test_write_read();
    logic [7:0] d [8], q [8], e [8];
    int nak, s0;
    d = '{8'h11, 8'h22, 8'h33, 0, 0, 0, 0, 0};
    s0 = stb[0];
    fork
      wr_txn(0, 8'h05, 3, d, nak);
      begin
        wclk(300);
        total++;
        if (busy[0] !== 1'b1) begin
          bad++; $display("FAIL wr_busy got=%b want=1", busy[0]);
        end
      end
    join
    mdl_wr(0, 8'h05, 3, d);
    total++;
    if (nak != 0) begin
      bad++; $display("FAIL wr_acks got=%0d nacks want=0", nak);
    end
    total++;
    if (stb[0] - s0 != 3) begin
      bad++; $display("FAIL wr_stb got=%0d want=3", stb[0] - s0);
    end
    total++;
    if (busy[0] !== 1'b0) begin
      bad++; $display("FAIL stop_busy got=%b want=0", busy[0]);
    end
    rd_txn(0, 1'b1, 8'h05, 3, q, nak);
    mdl_wr(0, 8'h05, 0, d);
    mdl_rd(0, 3, e);
    total++;
    if (nak != 0) begin
      bad++; $display("FAIL rd_acks got=%0d want=0", nak);
    end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (q[i] !== e[i]) begin
        bad++; $display("FAIL wr_rd%0d got=%h want=%h", i, q[i], e[i]);
      end
    end
    total++;
    if (sda_o[0] !== 1'b1) begin
      bad++; $display("FAIL rd_release got=%b want=1", sda_o[0]);
    end
  endtask

  task automatic test_nomatch();
    logic a;
    int s0;
    s0 = stb[0];
    i2c_start(0);
    wr_byte(0, {7'h50, 1'b0}, a);
    total++;
    if (a !== 1'b0) begin
      bad++; $display("FAIL nm_ack got=ack want=nack");
    end
    total++;
    if (busy[0] !== 1'b0) begin
      bad++; $display("FAIL nm_busy got=%b want=0", busy[0]);
    end
    wr_byte(0, 8'h00, a);
    wr_byte(0, 8'hA5, a);
    i2c_stop(0);
    total++;
    if (stb[0] != s0) begin
      bad++; $display("FAIL nm_stb got=%0d want=%0d", stb[0], s0);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] z [8], q [8], e [8];
    int nak;
    z = '{default: 8'h00};
    rd_txn(0, 1'b1, 8'h1F, 3, q, nak);
    mdl_wr(0, 8'h1F, 0, z);
    mdl_rd(0, 3, e);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (q[i] !== e[i]) begin
        bad++; $display("FAIL wrap%0d got=%h want=%h", i, q[i], e[i]);
      end
    end
    rd_txn(0, 1'b0, 8'h00, 1, q, nak);
    mdl_rd(0, 1, e);
    total++;
    if (q[0] !== e[0]) begin
      bad++; $display("FAIL wrap_keep got=%h want=%h", q[0], e[0]);
    end
  endtask

  task automatic test_concurrent();
    logic [7:0] d0 [8], d3 [8], q [8], e [8];
    logic [7:0] p0, p3;
    int n0, n3, s [NB];
    foreach (d0[i]) d0[i] = 8'($urandom);
    foreach (d3[i]) d3[i] = 8'($urandom);
    p0 = 8'($urandom);
    p3 = 8'($urandom);
    s = stb;
    fork
      wr_txn(0, p0, 3, d0, n0);
      wr_txn(3, p3, 3, d3, n3);
      begin
        wclk(300);
        total++;
        if (busy !== 4'b1001) begin
          bad++; $display("FAIL cc_busy got=%b want=1001", busy);
        end
      end
    join
    mdl_wr(0, p0, 3, d0);
    mdl_wr(3, p3, 3, d3);
    total++;
    if (n0 != 0 || n3 != 0) begin
      bad++; $display("FAIL cc_acks got=%0d/%0d want=0/0", n0, n3);
    end
    for (int b = 0; b < NB; b++) begin
      total++;
      if (stb[b] - s[b] != ((b == 0 || b == 3) ? 3 : 0)) begin
        bad++; $display("FAIL cc_stb%0d got=%0d", b, stb[b] - s[b]);
      end
    end
    for (int b = 0; b < NB; b++) begin
      rd_txn(b, 1'b1, p0, 3, q, n0);
      mdl_wr(b, p0, 0, d0);
      mdl_rd(b, 3, e);
      for (int i = 0; i < 3; i++) begin
        total++;
        if (q[i] !== e[i]) begin
          bad++;
          $display("FAIL cc_rd b%0d i%0d got=%h want=%h",
                   b, i, q[i], e[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] d [8], q [8], e [8];
    logic [7:0] p;
    int b, n, nak;
    for (int t = 0; t < 4; t++) begin
      b = $urandom_range(0, NB - 1);
      n = $urandom_range(1, 4);
      p = 8'($urandom);
      foreach (d[i]) d[i] = 8'($urandom);
      wr_txn(b, p, n, d, nak);
      mdl_wr(b, p, n, d);
      total++;
      if (nak != 0) begin
        bad++; $display("FAIL rnd_ack t%0d got=%0d want=0", t, nak);
      end
      p = p + 8'($urandom_range(0, 1));
      rd_txn(b, 1'b1, p, n, q, nak);
      mdl_wr(b, p, 0, d);
      mdl_rd(b, n, e);
      for (int i = 0; i < n; i++) begin
        total++;
        if (q[i] !== e[i]) begin
          bad++;
          $display("FAIL rnd t%0d i%0d got=%h want=%h",
                   t, i, q[i], e[i]);
        end
      end
    end
  endtask

  task automatic test_rst_mid();
    logic [7:0] z [8], q [8], e [8];
    logic a, r;
    int nak;
    z = '{default: 8'h00};
    wr_txn(1, 8'd10, 2, z, nak);
    wr_txn(1, 8'd10, 0, z, nak);
    i2c_start(1);
    wr_byte(1, {adr(1), 1'b1}, a);
    for (int i = 0; i < 3; i++) bitx(1, 1'b1, r);
    wclk(2);
    total++;
    if (sda_o[1] !== 1'b0 || busy[1] !== 1'b1) begin
      bad++;
      $display("FAIL pre_rst got=%b/%b want=0/1", sda_o[1], busy[1]);
    end
    rst = 1'b0;
    #1;
    total++;
    if (sda_o !== '1 || scl_o !== '1 || busy !== '0) begin
      bad++;
      $display("FAIL mid_rst got=%b/%b/%b want=1111/1111/0000",
               sda_o, scl_o, busy);
    end
    mdl_reset();
    wclk(3);
    rst = 1'b1;
    wclk(3);
    i2c_stop(1);
    rd_txn(1, 1'b0, 8'h00, 2, q, nak);
    mdl_rd(1, 2, e);
    total++;
    if (nak != 0) begin
      bad++; $display("FAIL post_rst_ack got=%0d want=0", nak);
    end
    for (int i = 0; i < 2; i++) begin
      total++;
      if (q[i] !== e[i]) begin
        bad++; $display("FAIL post_rst%0d got=%h want=%h", i, q[i], e[i]);
      end
    end
  endtask

`ifdef I2CMB_SLV_STRETCH_EN
  task automatic test_stretch();
    logic [7:0] d [8], q [8], e [8];
    int nak, r0, b0;
    foreach (d[i]) d[i] = 8'($urandom);
    r0 = runs;
    b0 = run_bad;
    wr_txn(0, 8'h03, 2, d, nak);
    mdl_wr(0, 8'h03, 2, d);
    wclk(2);
    total++;
    if (runs - r0 != 4) begin
      bad++; $display("FAIL st_runs got=%0d want=4", runs - r0);
    end
    total++;
    if (run_bad != b0) begin
      bad++; $display("FAIL st_len got=%0d bad runs want=0", run_bad - b0);
    end
    total++;
    if (nak != 0) begin
      bad++; $display("FAIL st_ack got=%0d want=0", nak);
    end
    rd_txn(0, 1'b1, 8'h03, 2, q, nak);
    mdl_wr(0, 8'h03, 0, d);
    mdl_rd(0, 2, e);
    for (int i = 0; i < 2; i++) begin
      total++;
      if (q[i] !== e[i]) begin
        bad++; $display("FAIL st_rd%0d got=%h want=%h", i, q[i], e[i]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_write_read();
    test_nomatch();
    test_wrap();
    test_concurrent();
    test_random();
    test_rst_mid();
`ifdef I2CMB_SLV_STRETCH_EN
    test_stretch();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2cmb_slave_array.md
# i2cmb_slave_array

Synthesizable multi-bus I2C target array: one independent register-file slave per I2C bus, sitting on the open-drain `scl`/`sda` wires alongside the `iicmb_m_wb` controller in the bench. It generalises the single-bus responder to `NUM_BUSES` channels, each with its own address, memory depth and auto-incrementing pointer. It adds optional clock stretching so the controller's SCL-hold handling can be exercised.

## Interface
Parameters:
- `NUM_BUSES`, 1, number of I2C buses/slave channels.
- `ADDR_BASE`, 7'h22, 7-bit address of channel 0; channel k answers `ADDR_BASE+k`.
- `MEM_DEPTH`, 32, bytes per channel; power of two, 2..256.
- `SYNC_STAGES`, 2, input synchroniser depth (>=2).
- `STRETCH_CYCLES`, 16, clk cycles of SCL hold (only with stretch macro).

Ports:
- `clk`  in  1  system clock; samples the I2C lines.
- `rst`  in  1  reset: asynchronous, active-low.
- `scl_i`  in  NUM_BUSES  sampled SCL per bus.
- `sda_i`  in  NUM_BUSES  sampled SDA per bus.
- `scl_o`  out  NUM_BUSES  SCL drive; 1 = release, 0 = pull low.
- `sda_o`  out  NUM_BUSES  SDA drive; 1 = release, 0 = pull low.
- `busy`  out  NUM_BUSES  channel addressed, transaction open.
- `wr_stb`  out  NUM_BUSES  1-cycle pulse per data byte stored.

## Operation
- Each channel runs an independent FSM: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR, WR_ACK, RD, RD_ACK.
- START is SDA falling while SCL is high. STOP is SDA rising while SCL is high. Both are detected in every state.
  - START re-enters ADDR (repeated start).
  - STOP forces IDLE, releases both lines and clears `busy`.
- ADDR: shift 8 bits MSB first on SCL rising edges.
  - If bits[7:1] equal `ADDR_BASE+k`: go to ADDR_ACK, drive ACK, set `busy`.
  - On mismatch: return to IDLE and never drive SDA.
- Write (R/W=0):
  - The first data byte is the pointer, stored as `byte % MEM_DEPTH`; go PTR, PTR_ACK.
  - Each later byte goes to `mem[ptr]`, pulses `wr_stb`, then `ptr <= ptr+1` mod MEM_DEPTH. Each is ACKed (WR, WR_ACK).
- Read (R/W=1): serve `mem[ptr]` MSB first, then increment ptr mod MEM_DEPTH (RD).
  - RD_ACK samples the master's bit. ACK continues RD; NACK releases SDA and goes to IDLE.
  - `busy` stays high until STOP.
- The pointer persists across transactions; only reset clears it (0).
- Memory reset value: `mem[i] = i[7:0]`.
- Wrap-around: the pointer at `MEM_DEPTH-1` wraps to 0 silently. No NACK on wrap.

## Timing
- Inputs pass through `SYNC_STAGES` flops, then one edge-detect flop. Event latency is SYNC_STAGES+1 clk after a pin change.
- SDA drive changes only one clk after a detected SCL falling edge.
  - ACK is asserted after the 8th bit's falling edge and released after the 9th.
  - Read data bit n is driven after the falling edge that precedes its rising edge.
- The first read bit is driven after the falling edge ending ADDR_ACK.
- `wr_stb` is asserted in the clk after the 8th rising edge of a data byte.
- Reset values: `scl_o`=all 1, `sda_o`=all 1, `busy`=0, `wr_stb`=0, FSM=IDLE, ptr=0.
- Reset mid-transfer: lines are released immediately (async). After reset the channel waits for a fresh START; bits in progress are ignored.
- START and STOP detected in the same clk on different buses are handled independently. No cross-channel coupling.
- Minimum supported: SCL high/low phases of at least SYNC_STAGES+3 clk.

## Configuration
- `I2CMB_SLV_STRETCH_EN` defined: after every ACK/NACK bit's falling edge, the channel holds `scl_o`=0 for `STRETCH_CYCLES` clk, then releases it. The FSM adds a STRETCH state and ignores SCL edges while in it.
- Undefined: `scl_o` is tied to all 1, with no STRETCH state and no stretch counter.

## Structure
- Shared package `i2cmb_slave_pkg`:
  - state enum `slv_state_t`;
  - the `I2C_DATA_WIDTH`=8 constant;
  - the ptr-width function `$clog2(MEM_DEPTH)`.
- One sub-module, `i2cmb_slave_chan`, holds the FSM, memory, synchroniser and stretch counter for one bus.
- The top generate-loops `NUM_BUSES` copies and passes `ADDR_BASE+k` to each.

## Test plan
- Write to 0x22, pointer 0x05, data 0x11 0x22 0x33, STOP. Then read 3 bytes after setting pointer 0x05. Required: ACK on all write bytes, 3 `wr_stb` pulses, read returns 0x11 0x22 0x33, and the last read byte is NACKed by the master.
- Address 0x50 with a single bus. Required: SDA stays released on the ACK bit, `busy` stays 0, memory unchanged.
- Write pointer 0x1F with MEM_DEPTH=32, then read 3 bytes. Required: 0x1F 0x00 0x01 (reset pattern), pointer wraps.
- NUM_BUSES=4, concurrent writes to bus 0 (0x22) and bus 3 (0x25). Required: each memory is updated only by its own bus; `busy` vectors independent.
- Assert `rst` low mid-byte of a read. Required: `sda_o`=1 in the same cycle; a subsequent STOP/START gives a clean transaction with ptr=0.
- With `I2CMB_SLV_STRETCH_EN`, STRETCH_CYCLES=16. Required: SCL held low for 16 clk after each ACK; the controller completes the write with correct data.
